// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS11 definitions for generator and checker
package prbs_pkg;

    localparam int PRBS_LEN = 11;
    localparam int TAP_A    = 0;
    localparam int TAP_B    = 2;
    localparam bit XNOR_FB  = 1'b1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    // Next sequence bit predicted from an 11-bit history (h[0] is the oldest bit)
    function automatic logic prbs_next_bit(input logic [PRBS_LEN-1:0] h);
        logic fb;
        fb = h[TAP_A] ^ h[TAP_B];
        return XNOR_FB ? ~fb : fb;
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// rtl/prbs_err_window.sv - non-sliding error window and loss-of-lock detect
module prbs_err_window #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic step_i,
    input  logic err_i,
    output logic loss_o
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(WINDOW + 1);

    logic [CW-1:0] win_cnt_q;
    logic [EW-1:0] win_err_q;
    logic [EW-1:0] win_err_inc;

    assign win_err_inc = win_err_q + EW'(1);

    // The error that brings the window total up to the threshold trips loss of lock
    assign loss_o = step_i & err_i & (win_err_inc == EW'(LOSS_THRESH));

    // Window position and error tally; both restart at lock entry and on each wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else if (restart_i) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else if (step_i) begin
            if (loss_o || (win_cnt_q == CW'(WINDOW - 1))) begin
                win_cnt_q <= '0;
                win_err_q <= '0;
            end else begin
                win_cnt_q <= win_cnt_q + CW'(1);
                if (err_i) begin
                    win_err_q <= win_err_inc;
                end
            end
        end
    end

endmodule

// File: rtl/prbs11_checker.sv
// rtl/prbs11_checker.sv - self-synchronising PRBS11 receive checker
module prbs11_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT    = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Clear,
    input  logic             DinValid,
    input  logic             Din,
    output logic             Locked,
    output logic             ErrPulse,
    output logic [ERR_W-1:0] ErrCount,
    output logic [ERR_W-1:0] BitCount
);

    localparam int FW = $clog2(PRBS_LEN);
    localparam int MW = $clog2(LOCK_CNT + 1);

    prbs_state_e         state_q;
    logic [PRBS_LEN-1:0] h_q;
    logic [FW-1:0]       fill_q;
    logic [MW-1:0]       match_q;
    logic                locked_q;
    logic                err_pulse_q;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0]    bit_cnt_q, bit_cnt_d;

    logic pred;
    logic mismatch;
    logic h_all_ones;
    logic chk_bit;
    logic chk_err;
    logic loss;

    assign pred       = prbs_next_bit(h_q);
    assign mismatch   = Din ^ pred;
    assign h_all_ones = &h_q;
    assign chk_bit    = DinValid & (state_q == ST_LOCKED);
    assign chk_err    = chk_bit & mismatch;

    prbs_err_window #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_err_window (
        .clk_i     (Clock),
        .rst_ni    (nReset),
        .restart_i (state_q != ST_LOCKED),
        .step_i    (chk_bit),
        .err_i     (mismatch),
        .loss_o    (loss)
    );

    // Acquisition FSM: fill history, verify predictions, then track on predicted bits
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_SEARCH;
            h_q      <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
        end else if (DinValid) begin
            case (state_q)
                ST_SEARCH: begin
                    h_q <= {Din, h_q[PRBS_LEN-1:1]};
                    if (fill_q == FW'(PRBS_LEN - 1)) begin
                        fill_q  <= '0;
                        state_q <= ST_VERIFY;
                    end else begin
                        fill_q <= fill_q + FW'(1);
                    end
                end
                ST_VERIFY: begin
                    // Received data reseeds the history while qualifying the lock
                    h_q <= {Din, h_q[PRBS_LEN-1:1]};
                    if (mismatch) begin
                        match_q <= '0;
                    end else if (!h_all_ones) begin
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            match_q  <= '0;
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            match_q <= match_q + MW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    // Self-predicted history keeps an isolated bit error from spreading
                    h_q <= {pred, h_q[PRBS_LEN-1:1]};
                    if (loss) begin
                        state_q  <= ST_SEARCH;
                        fill_q   <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a coincident Clear takes priority over increments
    always_comb begin
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (Clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            if (chk_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (chk_bit && (bit_cnt_q != '1)) begin
                bit_cnt_d = bit_cnt_q + ERR_W'(1);
            end
        end
    end

    // Registered error pulse and counters
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            err_pulse_q <= chk_err;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign Locked   = locked_q;
    assign ErrPulse = err_pulse_q;
    assign ErrCount = err_cnt_q;
    assign BitCount = bit_cnt_q;

endmodule
